beep_tone_gen: RTL and testbench
================================

BEEP_TONE_GEN -- requirements
Module: beep_tone_gen

Interface
REQ-001 The block SHALL provide parameter NOTE_LEN, default 32'd12_500_000, giving the note duration in clk cycles (0.25 s at 50 MHz; legal range 1..2^32-1).
REQ-002 The block SHALL provide parameter GAP_LEN, default 32'd2_500_000, giving the silent inter-note gap in clk cycles (legal range 1..2^32-1); it is used only when BEEP_GAP_EN is defined.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port period_in, input, 32 bits: tone period in clk cycles, supplied by the upstream note lookup table.
REQ-006 Port period_valid, input, 1 bit: period_in is valid this cycle.
REQ-007 Port period_ready, output, 1 bit: the block accepts period_in this cycle.
REQ-008 Port beep, output, 1 bit: registered square-wave drive for the buzzer.
REQ-009 Port note_done, output, 1 bit: single-cycle pulse marking the last cycle of a note.
REQ-010 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 The state machine SHALL have states IDLE, PLAY and GAP; GAP is reachable only when BEEP_GAP_EN is defined.
REQ-012 period_ready SHALL be 1 exactly when the state is IDLE, driven combinationally from the state register.
REQ-013 A handshake SHALL occur on any edge where period_valid and period_ready are both 1; period_valid while not ready is ignored and causes no side effect.
REQ-014 On a handshake edge:
- period_reg <= period_in;
- cnt <= 0 and dur <= 0;
- state <= PLAY;
- beep <= 1 if period_in >= 2, else beep <= 0.
REQ-015 In PLAY, cnt SHALL advance modulo period_reg on each edge: cnt_next = (cnt == period_reg-1) ? 0 : cnt+1.
REQ-016 In PLAY, beep SHALL be registered as beep <= (cnt_next < (period_reg >> 1)), so beep always equals (cnt < period_reg>>1); odd periods give a low phase one cycle longer than the high phase.
REQ-017 A period_reg of 0 or 1 SHALL be a rest: beep held 0 and cnt held 0 for the whole note, while dur still counts.
REQ-018 In PLAY, dur SHALL increment every cycle.
REQ-019 note_done SHALL be 1 exactly in the PLAY cycle where dur == NOTE_LEN-1.
REQ-020 On the edge ending the note_done cycle, the block SHALL set beep <= 0 and go to GAP (macro defined, with dur <= 0) or to IDLE (macro undefined).
REQ-021 In GAP, beep SHALL be held 0 and dur SHALL count; on the edge where dur == GAP_LEN-1 the state SHALL go to IDLE.
REQ-022 Every counter SHALL be 32 bits wide with no overflow beyond the limits above; all comparisons SHALL be unsigned.
REQ-023 Latency: from a handshake edge to the first beep high SHALL be 0 cycles (beep is high in the first PLAY cycle); the earliest next handshake SHALL be 1 cycle after note_done (macro undefined) or GAP_LEN+1 cycles after note_done (macro defined).

Reset
REQ-024 While rst = 0, the block SHALL force state = IDLE, beep = 0, note_done = 0, busy = 0, period_ready = 1, and cnt, dur and period_reg = 0, regardless of clk.
REQ-025 Reset asserted mid-note SHALL abort the note immediately with no note_done pulse; the first handshake after reset release SHALL behave exactly as a handshake after power-up.

Configuration
REQ-026 When macro BEEP_GAP_EN is defined, GAP state, GAP_LEN and the related logic SHALL be compiled in and a silent gap SHALL follow every note.
REQ-027 When BEEP_GAP_EN is not defined, GAP state and its logic SHALL be absent, and PLAY SHALL transition directly to IDLE after note_done.

Verification
REQ-028 Scenario, basic tone: NOTE_LEN=10, macro undefined; handshake with period_in=4 -> beep over PLAY cycles 0..9 reads 1,1,0,0,1,1,0,0,1,1; note_done high in cycle 9; period_ready = 1 in cycle 10.
REQ-029 Scenario, odd period: handshake with period_in=5, NOTE_LEN=10 -> beep reads 1,1,0,0,0,1,1,0,0,0.
REQ-030 Scenario, rest: handshake with period_in=0, then with period_in=1, NOTE_LEN=10 -> beep is 0 throughout each note; note_done still pulses in cycle 9; busy is high for 10 cycles.
REQ-031 Scenario, gap: BEEP_GAP_EN defined, NOTE_LEN=10, GAP_LEN=3, period_valid held at 1 -> beep is 0 and period_ready is 0 for 3 cycles after note_done; the next handshake occurs 4 cycles after note_done.
REQ-032 Scenario, back-pressure: change period_in to 191130 while PLAY is active -> the tone is unchanged; the new value is accepted only when period_ready returns to 1.
REQ-033 Scenario, mid-note reset: assert rst at dur=5 -> beep, busy and note_done go to 0 asynchronously with no note_done pulse; after release, period_in=4 reproduces the REQ-028 waveform.

Source files
------------

// File: rtl/beep_tone_gen.sv
// Buzzer tone generator: accepts a tone period through a ready/valid handshake,
// plays a square wave for NOTE_LEN cycles, then returns to idle.
// Optional feature macro: BEEP_GAP_EN adds a silent GAP_LEN-cycle gap after each note.
module beep_tone_gen #(
  parameter int unsigned NOTE_LEN = 32'd12_500_000,
  parameter int unsigned GAP_LEN  = 32'd2_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] period_in,
  input  logic        period_valid,
  output logic        period_ready,
  output logic        beep,
  output logic        note_done,
  output logic        busy
);

`ifdef BEEP_GAP_EN
  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;
  localparam logic [31:0] GapLast = GAP_LEN - 32'd1;
`else
  typedef enum logic [1:0] {StIdle, StPlay} state_e;
  // GAP_LEN only matters when the gap is compiled in.
  logic w_unused_gap;
  assign w_unused_gap = ^GAP_LEN;
`endif

  localparam logic [31:0] NoteLast = NOTE_LEN - 32'd1;

  state_e      r_state, w_state_next;
  logic [31:0] r_period, w_period_next;
  logic [31:0] r_cnt, w_cnt_next;
  logic [31:0] r_dur, w_dur_next;
  logic        r_beep, w_beep_next;

  logic        w_handshake;
  logic        w_rest;
  logic [31:0] w_cnt_adv;
  logic        w_note_last;

  // Handshake and status outputs decoded straight from the state register.
  always_comb begin
    period_ready = (r_state == StIdle);
    busy         = (r_state != StIdle);
    w_handshake  = period_valid && period_ready;
    w_note_last  = (r_dur == NoteLast);
    note_done    = (r_state == StPlay) && w_note_last;
    beep         = r_beep;
  end

  // Period counter advance; periods 0 and 1 are rests and keep the counter parked at 0.
  always_comb begin
    w_rest = (r_period < 32'd2);
    if (w_rest || (r_cnt == r_period - 32'd1)) begin
      w_cnt_adv = 32'd0;
    end else begin
      w_cnt_adv = r_cnt + 32'd1;
    end
  end

  // Next-state logic for the note sequencer.
  always_comb begin
    w_state_next  = r_state;
    w_period_next = r_period;
    w_cnt_next    = r_cnt;
    w_dur_next    = r_dur;
    w_beep_next   = r_beep;
    unique case (r_state)
      StIdle: begin
        w_beep_next = 1'b0;
        if (w_handshake) begin
          w_period_next = period_in;
          w_cnt_next    = 32'd0;
          w_dur_next    = 32'd0;
          w_state_next  = StPlay;
          // High phase starts in the very first PLAY cycle.
          w_beep_next   = (period_in >= 32'd2);
        end
      end
      StPlay: begin
        w_cnt_next  = w_cnt_adv;
        w_dur_next  = r_dur + 32'd1;
        w_beep_next = (w_cnt_adv < (r_period >> 1));
        if (w_note_last) begin
          w_beep_next = 1'b0;
`ifdef BEEP_GAP_EN
          w_dur_next   = 32'd0;
          w_state_next = StGap;
`else
          w_state_next = StIdle;
`endif
        end
      end
`ifdef BEEP_GAP_EN
      StGap: begin
        w_beep_next = 1'b0;
        w_dur_next  = r_dur + 32'd1;
        if (r_dur == GapLast) begin
          w_state_next = StIdle;
        end
      end
`endif
      default: begin
        w_state_next = StIdle;
        w_beep_next  = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= StIdle;
      r_period <= 32'd0;
      r_cnt    <= 32'd0;
      r_dur    <= 32'd0;
      r_beep   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_period <= w_period_next;
      r_cnt    <= w_cnt_next;
      r_dur    <= w_dur_next;
      r_beep   <= w_beep_next;
    end
  end

endmodule

// File: tb/tb_beep_tone_gen.sv
// Directed bench for beep_tone_gen with NOTE_LEN=10, GAP_LEN=3.
module tb_beep_tone_gen;

  localparam int unsigned NoteLen = 10;
  localparam int unsigned GapLen  = 3;
`ifdef BEEP_GAP_EN
  localparam int unsigned ExpGap = GapLen;
`else
  localparam int unsigned ExpGap = 0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] period_in;
  logic        period_valid;
  logic        period_ready;
  logic        beep;
  logic        note_done;
  logic        busy;

  int n_tests;
  int n_fail;

  beep_tone_gen #(
    .NOTE_LEN(NoteLen),
    .GAP_LEN (GapLen)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .period_in   (period_in),
    .period_valid(period_valid),
    .period_ready(period_ready),
    .beep        (beep),
    .note_done   (note_done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] period;
    logic [9:0]  pat;  // MSB is PLAY cycle 0
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Caller is positioned between a negedge and the following posedge with the DUT idle.
  task automatic play_note(input string name, input logic [31:0] p, input logic [9:0] pat);
    period_in    = p;
    period_valid = 1'b1;
    chk({name, "_ready_pre"}, {31'd0, period_ready}, 32'd1);
    @(posedge clk);
    #1 period_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("%s_beep_c%0d", name, i), {31'd0, beep}, {31'd0, pat[9-i]});
      chk($sformatf("%s_done_c%0d", name, i), {31'd0, note_done}, (i == 9) ? 32'd1 : 32'd0);
      chk($sformatf("%s_busy_c%0d", name, i), {31'd0, busy}, 32'd1);
      chk($sformatf("%s_rdy_c%0d", name, i), {31'd0, period_ready}, 32'd0);
    end
    for (int g = 0; g < int'(ExpGap); g++) begin
      @(negedge clk);
      chk($sformatf("%s_gap_beep%0d", name, g), {31'd0, beep}, 32'd0);
      chk($sformatf("%s_gap_rdy%0d", name, g), {31'd0, period_ready}, 32'd0);
      chk($sformatf("%s_gap_busy%0d", name, g), {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    chk({name, "_ready_post"}, {31'd0, period_ready}, 32'd1);
    chk({name, "_busy_post"}, {31'd0, busy}, 32'd0);
    chk({name, "_beep_post"}, {31'd0, beep}, 32'd0);
  endtask

  // Waits at negedges for period_ready; returns the number of cycles waited.
  task automatic wait_ready(input string name, output int waited);
    waited = 0;
    while (period_ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk({name, "_ready_reached"}, {31'd0, period_ready}, 32'd1);
  endtask

  initial begin
    int w;
    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{"p4",   32'd4,      10'b1100110011};
    vecs[1] = '{"p5",   32'd5,      10'b1100011000};
    vecs[2] = '{"p0",   32'd0,      10'b0000000000};
    vecs[3] = '{"p1",   32'd1,      10'b0000000000};
    vecs[4] = '{"p2",   32'd2,      10'b1010101010};
    vecs[5] = '{"p3",   32'd3,      10'b1001001001};
    vecs[6] = '{"p6",   32'd6,      10'b1110001110};
    vecs[7] = '{"pbig", 32'd191130, 10'b1111111111};

    // Reset state, checked before any clock edge.
    rst          = 1'b0;
    period_in    = 32'd7;
    period_valid = 1'b1;
    #3;
    chk("rst_beep", {31'd0, beep}, 32'd0);
    chk("rst_done", {31'd0, note_done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, period_ready}, 32'd1);
    // Valid held through reset must not start a note.
    repeat (2) @(negedge clk);
    chk("rst_hold_busy", {31'd0, busy}, 32'd0);
    period_valid = 1'b0;
    rst = 1'b1;

    foreach (vecs[k]) play_note(vecs[k].name, vecs[k].period, vecs[k].pat);

    // Back-pressure: new value presented during PLAY waits for ready.
    period_in    = 32'd4;
    period_valid = 1'b1;
    @(posedge clk);
    #1 period_in = 32'd191130;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp_beep_c%0d", i), {31'd0, beep}, {31'd0, vecs[0].pat[9-i]});
      chk($sformatf("bp_rdy_c%0d", i), {31'd0, period_ready}, 32'd0);
    end
    wait_ready("bp_first", w);
    chk("bp_gap_cycles", w, ExpGap + 1);
    @(posedge clk);
    #1 period_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("bp_new_beep%0d", i), {31'd0, beep}, 32'd1);
      chk($sformatf("bp_new_busy%0d", i), {31'd0, busy}, 32'd1);
    end
    wait_ready("bp_second", w);

    // Mid-note reset at dur=5.
    period_in    = 32'd4;
    period_valid = 1'b1;
    @(posedge clk);
    #1 period_valid = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);
    chk("mr_beep_before", {31'd0, beep}, 32'd1);
    chk("mr_busy_before", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mr_beep_async", {31'd0, beep}, 32'd0);
    chk("mr_busy_async", {31'd0, busy}, 32'd0);
    chk("mr_done_async", {31'd0, note_done}, 32'd0);
    chk("mr_ready_async", {31'd0, period_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("mr_no_done%0d", i), {31'd0, note_done}, 32'd0);
    end
    rst = 1'b1;
    play_note("mr_after", 32'd4, 10'b1100110011);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
